irq_controller: RTL

//  Memory-mapped interrupt controller on the dbus slave side, sitting directly upstream of the CPU's

---
 rtl/irq_controller_if.sv | 25 ++
 rtl/irq_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/irq_controller_if.sv
// Data-bus slave port of the interrupt controller: byte address, write data, read data, strobes.
// Reads are combinational in the strobe cycle; writes land on the strobe cycle's clock edge; never stalls.
interface irq_controller_if;
    logic [7:0]  bus_address;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_read;
    logic        bus_write;

    modport master (
        output bus_address,
        output bus_data_i,
        output bus_read,
        output bus_write,
        input  bus_data_o
    );

    modport slave (
        input  bus_address,
        input  bus_data_i,
        input  bus_read,
        input  bus_write,
        output bus_data_o
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: synchronises, latches (level/edge), masks and routes requests onto CPU irq lines.
// Latency src_in -> irq_line is SYNC_STAGES+2 edges; bus reads are combinational, no backpressure.
module irq_controller #(
    parameter int NUM_SRC     = 8,
    parameter int NUM_OUT     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_bus,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_in,
    irq_controller_if.slave    bus,
    output logic [NUM_OUT-1:0] irq_line
);

    localparam logic [5:0] A_RAW     = 6'h00;
    localparam logic [5:0] A_PENDING = 6'h01;
    localparam logic [5:0] A_ENABLE  = 6'h02;
    localparam logic [5:0] A_MODE    = 6'h03;
    localparam logic [5:0] A_ROUTE   = 6'h04;
    localparam logic [5:0] A_CLAIM   = 6'h05;

    function automatic logic [4*NUM_SRC-1:0] route_reset_val();
        logic [4*NUM_SRC-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            v[4*i +: 4] = (i < NUM_OUT) ? 4'(i) : 4'hF;
        end
        return v;
    endfunction

    localparam logic [4*NUM_SRC-1:0] ROUTE_RST = route_reset_val();

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
    logic [NUM_SRC-1:0]   prev_q, prev_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   enable_q, enable_d;
    logic [NUM_SRC-1:0]   mode_q, mode_d;
    logic [4*NUM_SRC-1:0] route_q, route_d;
    logic [NUM_OUT-1:0]   irq_line_q, irq_line_d;

    logic [NUM_SRC-1:0] synced;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] active;
    logic [5:0]         word_addr;
    logic               wr_pending, wr_enable, wr_mode, wr_route;
    logic [2:0]         claim_idx;
    logic [31:0]        rdata;
    logic               unused_bus_bits;

    assign word_addr  = bus.bus_address[7:2];
    assign wr_pending = bus.bus_write && (word_addr == A_PENDING);
    assign wr_enable  = bus.bus_write && (word_addr == A_ENABLE);
    assign wr_mode    = bus.bus_write && (word_addr == A_MODE);
    assign wr_route   = bus.bus_write && (word_addr == A_ROUTE);

    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = synced & ~prev_q;
    assign w1c    = wr_pending ? bus.bus_data_i[NUM_SRC-1:0] : '0;
    assign active = pending_q & enable_q;

    // Byte-lane bits and write-data bits above the implemented sources carry no meaning here.
    assign unused_bus_bits = ^{bus.bus_address[1:0], bus.bus_data_i};

    always_comb begin
        sync_d = sync_q;
        sync_d[0] = src_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = synced;

        // A fresh rising edge outranks a same-cycle W1C; level sources simply follow the synchronised input.
        pending_d = (mode_q & (rise | (pending_q & ~w1c))) | (~mode_q & synced);

        enable_d = wr_enable ? bus.bus_data_i[NUM_SRC-1:0] : enable_q;
        mode_d   = wr_mode   ? bus.bus_data_i[NUM_SRC-1:0] : mode_q;
        route_d  = wr_route  ? bus.bus_data_i[4*NUM_SRC-1:0] : route_q;
    end

    // Route values at or above NUM_OUT never match a line index, so those sources stay silent.
    always_comb begin
        irq_line_d = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (active[i] && (route_q[4*i +: 4] == 4'(k))) begin
                    irq_line_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        claim_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_idx = 3'(i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (word_addr)
            A_RAW:     rdata[NUM_SRC-1:0]   = synced;
            A_PENDING: rdata[NUM_SRC-1:0]   = pending_q;
            A_ENABLE:  rdata[NUM_SRC-1:0]   = enable_q;
            A_MODE:    rdata[NUM_SRC-1:0]   = mode_q;
            A_ROUTE:   rdata[4*NUM_SRC-1:0] = route_q;
            A_CLAIM: begin
                rdata[31]  = |active;
                rdata[2:0] = claim_idx;
            end
            default:   rdata = '0;
        endcase
    end

    assign bus.bus_data_o = bus.bus_read ? rdata : 32'h0;
    assign irq_line       = irq_line_q;

    always_ff @(posedge clk_bus) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            route_q    <= ROUTE_RST;
            irq_line_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            route_q    <= route_d;
            irq_line_q <= irq_line_d;
        end
    end

endmodule
